// File: rtl/switch_port.sv
// Memory-mapped switch input port: synchronises and debounces up to 32 switches,
// latches sticky change events and raises a maskable level interrupt.
module switch_port #(
    parameter int SW_WIDTH  = 24,
    parameter int DB_CYCLES = 65536
) (
    input  logic                switclk,
    input  logic                switrst,
    input  logic                switchcs,
    input  logic [2:0]          switchaddr,
    input  logic                switchread,
    input  logic                switchwrite,
    input  logic [15:0]         switchwdata,
    output logic [15:0]         switchrdata,
    input  logic [SW_WIDTH-1:0] switch_i,
    output logic                switch_irq
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [31:0] VALID = (SW_WIDTH >= 32) ? 32'hFFFF_FFFF
                                  : 32'((64'd1 << SW_WIDTH) - 64'd1);

    logic [SW_WIDTH-1:0] sync1;
    logic [SW_WIDTH-1:0] sync2;
    logic [31:0]         deb;
    logic [31:0]         deb_nxt;
    logic [31:0]         flip;
    logic [31:0]         evt;
    logic [31:0]         evt_clr;
    logic [31:0]         mask;
    logic [31:0]         mask_nxt;
    logic [CW-1:0]       cnt     [SW_WIDTH];
    logic [CW-1:0]       cnt_nxt [SW_WIDTH];
    logic [15:0]         rsel;
    logic                rd_en;
    logic                wr_en;

    assign rd_en = switchcs && switchread;
    assign wr_en = switchcs && switchwrite;

    // A bit is accepted only after DB_CYCLES consecutive samples disagree with deb.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < SW_WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (sync2[i] == deb[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                deb_nxt[i] = sync2[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    assign flip = deb ^ deb_nxt;

    always_comb begin
        evt_clr  = '0;
        mask_nxt = mask;
        if (wr_en) begin
            case (switchaddr)
                3'd2:    evt_clr[15:0]   = switchwdata;
                3'd3:    evt_clr[31:16]  = switchwdata;
                3'd4:    mask_nxt[15:0]  = switchwdata;
                3'd5:    mask_nxt[31:16] = switchwdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (switchaddr)
            3'd0:    rsel = deb[15:0];
            3'd1:    rsel = deb[31:16];
            3'd2:    rsel = evt[15:0];
            3'd3:    rsel = evt[31:16];
            3'd4:    rsel = mask[15:0];
            3'd5:    rsel = mask[31:16];
            default: rsel = 16'h0000;
        endcase
    end

    // New edges are OR-ed in after the clear so a same-edge set beats a W1C.
    always_ff @(posedge switclk or posedge switrst) begin
        if (switrst) begin
            sync1       <= '0;
            sync2       <= '0;
            deb         <= '0;
            evt         <= '0;
            mask        <= '0;
            switchrdata <= '0;
            for (int i = 0; i < SW_WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync1 <= switch_i;
            sync2 <= sync1;
            deb   <= deb_nxt & VALID;
            evt   <= ((evt & ~evt_clr) | flip) & VALID;
            mask  <= mask_nxt & VALID;
            for (int i = 0; i < SW_WIDTH; i++) cnt[i] <= cnt_nxt[i];
            if (rd_en) switchrdata <= rsel;
        end
    end

    assign switch_irq = |(evt & mask);

endmodule

// File: tb/tb_switch_port.sv
// Bench for switch_port: directed corner cases plus random traffic checked
// against a sample-window reference model.
module tb_switch_port;

    localparam int SW = 24;
    localparam int DB = 4;
    localparam logic [31:0] VALID = 32'h00FF_FFFF;

    logic          switclk = 1'b0;
    logic          switrst = 1'b1;
    logic          switchcs = 1'b0;
    logic [2:0]    switchaddr = '0;
    logic          switchread = 1'b0;
    logic          switchwrite = 1'b0;
    logic [15:0]   switchwdata = '0;
    logic [15:0]   switchrdata;
    logic [SW-1:0] switch_i = '0;
    logic          switch_irq;

    int total = 0;
    int passed = 0;

    // Reference model state: a bit flips once the last DB synchronised samples agree and differ from deb.
    logic [31:0]   m_deb, m_evt, m_mask;
    logic [15:0]   m_rdata;
    logic [SW-1:0] hist [0:DB];

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[$];

    switch_port #(.SW_WIDTH(SW), .DB_CYCLES(DB)) dut (
        .switclk(switclk), .switrst(switrst), .switchcs(switchcs),
        .switchaddr(switchaddr), .switchread(switchread), .switchwrite(switchwrite),
        .switchwdata(switchwdata), .switchrdata(switchrdata),
        .switch_i(switch_i), .switch_irq(switch_irq)
    );

    always #5 switclk = ~switclk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] model_sel(input logic [2:0] a);
        case (a)
            3'd0:    return m_deb[15:0];
            3'd1:    return m_deb[31:16];
            3'd2:    return m_evt[15:0];
            3'd3:    return m_evt[31:16];
            3'd4:    return m_mask[15:0];
            3'd5:    return m_mask[31:16];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_deb = '0; m_evt = '0; m_mask = '0; m_rdata = '0;
        for (int d = 0; d <= DB; d++) hist[d] = '0;
    endtask

    task automatic model_edge();
        logic [SW-1:0] stable;
        logic [31:0]   flip, clr, nmask;
        stable = '1;
        for (int d = 1; d < DB; d++) stable &= ~(hist[d] ^ hist[d+1]);
        flip  = 32'(stable & (hist[1] ^ m_deb[SW-1:0]));
        if (switchcs && switchread) m_rdata = model_sel(switchaddr);
        clr   = '0;
        nmask = m_mask;
        if (switchcs && switchwrite) begin
            case (switchaddr)
                3'd2: clr[15:0]    = switchwdata;
                3'd3: clr[31:16]   = switchwdata;
                3'd4: nmask[15:0]  = switchwdata;
                3'd5: nmask[31:16] = switchwdata;
                default: ;
            endcase
        end
        m_evt  = (m_evt & ~clr) | flip;
        m_mask = nmask & VALID;
        m_deb  = m_deb ^ flip;
        for (int d = DB; d > 0; d--) hist[d] = hist[d-1];
        hist[0] = switch_i;
    endtask

    task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                                 input logic [2:0] addr, input logic [15:0] wdata);
        switchcs    = cs;
        switchread  = rd;
        switchwrite = wr;
        switchaddr  = addr;
        switchwdata = wdata;
    endtask

    task automatic step();
        @(posedge switclk);
        model_edge();
        @(negedge switclk);
        checkOutput("model_rdata", 32'(switchrdata), 32'(m_rdata));
        checkOutput("model_irq", 32'(switch_irq), 32'(|(m_evt & m_mask)));
    endtask

    task automatic do_reset();
        switrst = 1'b1;
        #1;
        checkOutput("reset_rdata", 32'(switchrdata), 32'h0);
        checkOutput("reset_irq", 32'(switch_irq), 32'h0);
        @(negedge switclk);
        @(negedge switclk);
        model_reset();
        switrst = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [2:0] addr, input logic [15:0] exp);
        applyStimulus(1'b1, 1'b1, 1'b0, addr, 16'h0);
        step();
        checkOutput(name, 32'(switchrdata), 32'(exp));
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
        applyStimulus(1'b1, 1'b0, 1'b1, addr, data);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        model_reset();
        @(negedge switclk);
        do_reset();

        // Reset/idle: every address reads zero.
        for (int a = 0; a < 8; a++) vecs.push_back('{addr: 3'(a), exp: 16'h0000});
        foreach (vecs[i]) read_expect("idle_read", vecs[i].addr, vecs[i].exp);

        // Debounce accept: deb[0] flips DB edges after sync2 sees the change.
        switch_i = 24'h00_0001;
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("accept_pre", 32'(switchrdata), 32'h0);
        end
        step();
        checkOutput("accept_post", 32'(switchrdata), 32'h1);
        read_expect("accept_event", 3'd2, 16'h0001);

        // Glitch reject: three high samples are one short of acceptance.
        switch_i = '0;
        do_reset();
        switch_i = 24'h00_0008;
        for (int i = 0; i < 3; i++) step();
        switch_i = '0;
        for (int i = 0; i < 8; i++) step();
        read_expect("glitch_deb", 3'd0, 16'h0000);
        read_expect("glitch_event", 3'd2, 16'h0000);

        // High byte: masked bit 23 raises irq on the deb edge.
        write_reg(3'd5, 16'h0080);
        switch_i = 24'h80_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("hi_irq_low", 32'(switch_irq), 32'h0);
        end
        step();
        checkOutput("hi_irq_rise", 32'(switch_irq), 32'h1);
        vecs.delete();
        vecs.push_back('{addr: 3'd1, exp: 16'h0080});
        vecs.push_back('{addr: 3'd3, exp: 16'h0080});
        vecs.push_back('{addr: 3'd5, exp: 16'h0080});
        vecs.push_back('{addr: 3'd0, exp: 16'h0000});
        foreach (vecs[i]) read_expect("hi_read", vecs[i].addr, vecs[i].exp);

        // W1C colliding with a new flip: the set wins.
        write_reg(3'd3, 16'h0080);
        checkOutput("w1c_hi_irq", 32'(switch_irq), 32'h0);
        write_reg(3'd4, 16'h0001);
        switch_i = 24'h80_0001;
        for (int i = 0; i < 6; i++) step();
        checkOutput("evt0_irq", 32'(switch_irq), 32'h1);
        switch_i = 24'h80_0000;
        for (int i = 0; i < 5; i++) step();
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 16'h0001);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        checkOutput("collide_irq", 32'(switch_irq), 32'h1);
        read_expect("collide_event", 3'd2, 16'h0001);
        read_expect("collide_deb", 3'd0, 16'h0000);
        write_reg(3'd2, 16'h0001);
        checkOutput("w1c_irq_fall", 32'(switch_irq), 32'h0);
        read_expect("w1c_event", 3'd2, 16'h0000);

        // Reset two cycles before a pending flip: the change re-qualifies from scratch.
        switch_i = 24'h80_0001;
        for (int i = 0; i < 3; i++) step();
        do_reset();
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 16'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("rst_mid_pre", 32'(switchrdata), 32'h0);
        end
        step();
        checkOutput("rst_mid_post", 32'(switchrdata), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(7) == 0) switch_i = switch_i ^ (24'd1 << $urandom_range(SW - 1));
            if ($urandom_range(60) == 0) switch_i = 24'($urandom);
            applyStimulus($urandom_range(3) != 0, 1'($urandom), $urandom_range(3) == 0,
                          3'($urandom), 16'($urandom));
            if ($urandom_range(400) == 0) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
                do_reset();
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
